// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, controller states and the
// result flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_SHL = 3'b000,
        OP_SHR = 3'b001,
        OP_SUB = 3'b010,
        OP_MUL = 3'b011,
        OP_ADD = 3'b100,
        OP_AND = 3'b101,
        OP_OR  = 3'b110,
        OP_NOT = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DONE    = 2'd2
    } alu_state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic neg;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Radix-2 shift-add multiplier: one partial product per cycle, WIDTH cycles
// per operation, keeping only the low WIDTH bits of the product.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // product is the accumulator after the current step, so it is final
    // during the cycle where done is high.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign busy     = (cnt_q != '0);
    assign done     = (cnt_q == CNT_W'(1));
    assign product  = acc_step;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = operand_a;
            mplier_d = operand_b;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
        end else if (busy) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops complete on the accept edge, MUL runs on the
// iterative multiplier; one operation in flight, result held until taken.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_neg
);

    // Handshake: a request transfers on a rising edge with in_valid && in_ready,
    // a result on a rising edge with out_valid && out_ready; result and flags
    // are stable while out_valid is high and out_ready is low.

    localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

    alu_state_t       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;

    alu_op_t          op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             big_shift;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             load_carry;

    assign op        = alu_op_t'(operation);
    assign sum       = {1'b0, operand1} + {1'b0, operand2};
    assign diff      = {1'b0, operand1} - {1'b0, operand2};
    assign big_shift = (operand2 >= SHIFT_LIM);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_SHL: alu_res = big_shift ? '0 : (operand1 << operand2);
            OP_SHR: alu_res = big_shift ? '0 : (operand1 >> operand2);
            OP_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = ~diff[WIDTH];
            end
            OP_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
            end
            OP_AND: alu_res = operand1 & operand2;
            OP_OR:  alu_res = operand1 | operand2;
            OP_NOT: alu_res = ~operand1;
            default: alu_res = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .operand_a (operand1),
        .operand_b (operand2),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        flags_d    = flags_q;
        load       = 1'b0;
        load_val   = alu_res;
        load_carry = alu_carry;
        mul_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL_RUN;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_MUL_RUN: begin
                // A multiplier that is not busy here can only mean lost state; recover.
                if (!mul_busy) begin
                    state_d = ST_IDLE;
                end else if (mul_done) begin
                    load       = 1'b1;
                    load_val   = mul_product;
                    load_carry = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            result_d      = load_val;
            flags_d.zero  = (load_val == '0);
            flags_d.carry = load_carry;
            flags_d.neg   = load_val[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign result     = result_q;
    assign flag_zero  = flags_q.zero;
    assign flag_carry = flags_q.carry;
    assign flag_neg   = flags_q.neg;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=16: per-feature tasks with hand-computed
// expected results, flags, latencies and handshake behaviour.
module tb_seq_alu;

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    // Flags are packed as {zero, carry, neg}.
    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  fl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  operation = 3'b000;
    logic [15:0] operand1 = 16'h0000;
    logic [15:0] operand2 = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        flag_zero;
    logic        flag_carry;
    logic        flag_neg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operation  (operation),
        .operand1   (operand1),
        .operand2   (operand2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_neg   (flag_neg)
    );

    // Drive one request; returns just after its accept edge with operands scrambled.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        in_valid  = 1'b1;
        operation = op;
        operand1  = a;
        operand2  = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operation = 3'($urandom_range(0, 7));
        operand1  = 16'($urandom);
        operand2  = 16'($urandom);
    endtask

    // Counts cycles after the accept edge until out_valid; -1 on timeout.
    task automatic wait_result(output int lat, output bit rdy_seen);
        lat      = -1;
        rdy_seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
            if (in_ready) rdy_seen = 1'b1;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [18:0] got, output int lat, output bit rdy_seen);
        issue(op, a, b);
        wait_result(lat, rdy_seen);
        got = {result, flag_zero, flag_carry, flag_neg};
        if (lat > 0) take_result();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_hs: got valid/ready %b want 01", {out_valid, in_ready});
        end
        total++;
        if ({result, flag_zero, flag_carry, flag_neg} !== 19'h0) begin
            bad++;
            $display("FAIL reset_out: got %h want 0", {result, flag_zero, flag_carry, flag_neg});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_release: got valid/ready %b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_add_sub();
        vec_t v[7];
        logic [18:0] got;
        int lat;
        bit rs;
        v[0] = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 3'b110};
        v[1] = '{OP_ADD, 16'h1234, 16'h4321, 16'h5555, 3'b000};
        v[2] = '{OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 3'b001};
        v[3] = '{OP_ADD, 16'h8000, 16'h8001, 16'h0001, 3'b010};
        v[4] = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 3'b001};
        v[5] = '{OP_SUB, 16'h0005, 16'h0003, 16'h0002, 3'b010};
        v[6] = '{OP_SUB, 16'h0007, 16'h0007, 16'h0000, 3'b110};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, got, lat, rs);
            total++;
            if (got !== {v[i].res, v[i].fl}) begin
                bad++;
                $display("FAIL add_sub[%0d]: got %h want %h", i, got, {v[i].res, v[i].fl});
            end
            total++;
            if (lat !== 1) begin
                bad++;
                $display("FAIL add_sub_lat[%0d]: got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_shift_logic();
        vec_t v[8];
        logic [18:0] got;
        int lat;
        bit rs;
        v[0] = '{OP_SHL, 16'h0001, 16'h0010, 16'h0000, 3'b100};
        v[1] = '{OP_SHR, 16'h8000, 16'h000F, 16'h0001, 3'b000};
        v[2] = '{OP_SHL, 16'h0001, 16'h000F, 16'h8000, 3'b001};
        v[3] = '{OP_SHR, 16'h8000, 16'hFFFF, 16'h0000, 3'b100};
        v[4] = '{OP_SHL, 16'h00F0, 16'h0004, 16'h0F00, 3'b000};
        v[5] = '{OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 3'b000};
        v[6] = '{OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 3'b001};
        v[7] = '{OP_OR,  16'h0000, 16'h0000, 16'h0000, 3'b100};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, got, lat, rs);
            total++;
            if (got !== {v[i].res, v[i].fl}) begin
                bad++;
                $display("FAIL shift_logic[%0d]: got %h want %h", i, got, {v[i].res, v[i].fl});
            end
            total++;
            if (lat !== 1) begin
                bad++;
                $display("FAIL shift_logic_lat[%0d]: got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_mul();
        vec_t v[4];
        logic [18:0] got;
        int lat;
        bit rs;
        v[0] = '{OP_MUL, 16'h0123, 16'h0010, 16'h1230, 3'b000};
        v[1] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 3'b000};
        v[2] = '{OP_MUL, 16'h0000, 16'h1234, 16'h0000, 3'b100};
        v[3] = '{OP_MUL, 16'h00FF, 16'h0101, 16'hFFFF, 3'b001};
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, got, lat, rs);
            total++;
            if (got !== {v[i].res, v[i].fl}) begin
                bad++;
                $display("FAIL mul[%0d]: got %h want %h", i, got, {v[i].res, v[i].fl});
            end
            total++;
            if (lat !== 17) begin
                bad++;
                $display("FAIL mul_lat[%0d]: got %0d want 17", i, lat);
            end
            total++;
            if (rs !== 1'b0) begin
                bad++;
                $display("FAIL mul_ready[%0d]: in_ready seen %b want 0", i, rs);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] got;
        int lat;
        bit rs;
        issue(OP_OR, 16'h00F0, 16'h0F00);
        wait_result(lat, rs);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL stall_lat: got %0d want 1", lat);
        end
        in_valid  = 1'b1;
        operation = OP_ADD;
        operand1  = 16'h0001;
        operand2  = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = {result, flag_zero, flag_carry, flag_neg};
            total++;
            if ({out_valid, in_ready, got} !== {2'b10, 16'h0FF0, 3'b000}) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i,
                         {out_valid, in_ready, got}, {2'b10, 16'h0FF0, 3'b000});
            end
        end
        take_result();
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL after_hs: got valid/ready %b want 01", {out_valid, in_ready});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        operand1 = 16'hDEAD;
        operand2 = 16'hBEEF;
        wait_result(lat, rs);
        got = {result, flag_zero, flag_carry, flag_neg};
        total++;
        if (got !== {16'h0002, 3'b000} || lat !== 1) begin
            bad++;
            $display("FAIL queued_add: got %h lat %0d want %h lat 1", got, lat, {16'h0002, 3'b000});
        end
        if (lat > 0) take_result();
    endtask

    task automatic test_reset_mid_op();
        logic [18:0] got;
        int lat;
        bit rs;
        bit seen_valid;
        issue(OP_MUL, 16'h0123, 16'h0010);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, result, flag_zero, flag_carry, flag_neg} !== {2'b01, 19'h0}) begin
            bad++;
            $display("FAIL rst_mul_hold: got %h want %h",
                     {out_valid, in_ready, result, flag_zero, flag_carry, flag_neg}, {2'b01, 19'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid || !in_ready) seen_valid = 1'b1;
        end
        total++;
        if (seen_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mul_abandon: got activity %b want 0", seen_valid);
        end
        run_op(OP_ADD, 16'h0002, 16'h0002, got, lat, rs);
        total++;
        if (got !== {16'h0004, 3'b000} || lat !== 1) begin
            bad++;
            $display("FAIL rst_then_add: got %h lat %0d want %h lat 1", got, lat, {16'h0004, 3'b000});
        end
        issue(OP_ADD, 16'hFFFF, 16'hFFFF);
        wait_result(lat, rs);
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, result, flag_zero, flag_carry, flag_neg} !== {2'b01, 19'h0}) begin
            bad++;
            $display("FAIL rst_done: got %h want %h",
                     {out_valid, in_ready, result, flag_zero, flag_carry, flag_neg}, {2'b01, 19'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL rst_done_after: got valid/ready %b want 01", {out_valid, in_ready});
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift_logic();
        test_mul();
        test_back_to_back();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
